// File: rtl/split_reg_bank_pkg.sv
// split_pkg: shared definitions for split_reg_bank.
//   - wr_mode encodings (LOAD / SET / CLEAR / TOGGLE)
//   - pulse-bit state type
//   - next_bit(): per-bit write result from (current bit, field bit, mode)
package split_pkg;

  localparam logic [1:0] MODE_LOAD   = 2'b00;
  localparam logic [1:0] MODE_SET    = 2'b01;
  localparam logic [1:0] MODE_CLEAR  = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  typedef enum logic {
    PB_IDLE   = 1'b0,
    PB_ACTIVE = 1'b1
  } pb_state_t;

  // Value a bit takes after a write of field bit f in the given mode.
  function automatic logic next_bit(input logic q, input logic f, input logic [1:0] mode);
    logic r;
    r = q;
    case (mode)
      MODE_LOAD:   r = f;
      MODE_SET:    r = q | f;
      MODE_CLEAR:  r = q & ~f;
      MODE_TOGGLE: r = q ^ f;
      default:     r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/split_reg_bank_pulse_bit_timer.sv
// pulse_bit_timer: one self-clearing strobe bit.
//   clk, rst  : clock, synchronous active-high reset
//   set_req   : start or retrigger the strobe (bit high, counter reloads)
//   clr_req   : cancel the strobe immediately (bit low, counter zero)
//   bit_q     : registered strobe output, high for exactly PULSE_LEN cycles
//   active    : bit high or counter non-zero
module pulse_bit_timer
  import split_pkg::*;
#(
  parameter int PULSE_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic bit_q,
  output logic active
);

  localparam int CW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PULSE_LEN - 1);

  pb_state_t     state;
  logic [CW-1:0] cnt;

  // A write always takes priority over expiry; cancel beats start (they are
  // mutually exclusive from the top level anyway).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PB_IDLE;
      cnt   <= '0;
    end else if (clr_req) begin
      state <= PB_IDLE;
      cnt   <= '0;
    end else if (set_req) begin
      state <= PB_ACTIVE;
      cnt   <= RELOAD;
    end else if (state == PB_ACTIVE) begin
      // Counter runs PULSE_LEN-1 .. 0; the bit drops on the edge after 0.
      if (cnt == '0) state <= PB_IDLE;
      else           cnt   <= cnt - 1'b1;
    end
  end

  assign bit_q  = (state == PB_ACTIVE);
  assign active = bit_q | (cnt != '0);

endmodule

// File: rtl/split_reg_bank.sv
// split_reg_bank: CPU-writable bank of NUM_OUT control bits taken from
// wr_data[LSB+NUM_OUT-1:LSB], with LOAD/SET/CLEAR/TOGGLE writes and optional
// self-clearing strobe bits (PULSE_MASK).
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : write strobe, one write per cycle
//   wr_mode   : 00 LOAD, 01 SET, 10 CLEAR, 11 TOGGLE
//   wr_data   : write word; bits outside the field are ignored
//   out_bits  : registered output bits
//   rd_data   : out_bits at their field position, zero elsewhere
//   busy      : registered; high while any strobe is in flight
module split_reg_bank
  import split_pkg::*;
#(
  parameter int                   DATA_W     = 32,
  parameter int                   NUM_OUT    = 17,
  parameter int                   LSB        = 0,
  parameter logic [NUM_OUT-1:0]   RESET_VAL  = '0,
  parameter logic [NUM_OUT-1:0]   PULSE_MASK = '0,
  parameter int                   PULSE_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_mode,
  input  logic [DATA_W-1:0] wr_data,
  output logic [NUM_OUT-1:0] out_bits,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  if (LSB + NUM_OUT > DATA_W || NUM_OUT < 1) begin : g_bad_field
    $error("split_reg_bank: field LSB+NUM_OUT exceeds DATA_W");
  end
  if (PULSE_LEN < 1) begin : g_bad_len
    $error("split_reg_bank: PULSE_LEN must be >= 1");
  end

  localparam logic [DATA_W-1:0] FIELD = DATA_W'({NUM_OUT{1'b1}}) << LSB;

  logic [NUM_OUT-1:0] active;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_bit
    logic f;
    logic wr_res;
    assign f      = wr_data[LSB+i];
    assign wr_res = next_bit(out_bits[i], f, wr_mode);

    if (PULSE_MASK[i]) begin : g_pulse
      logic set_req, clr_req;
      // Result 1 with f=1 is LOAD/SET of a 1 or TOGGLE of a low bit: start or
      // retrigger. Result 0 on a high bit is a cancel; on a low bit it is a
      // harmless no-op since the counter is already zero.
      assign set_req = wr_en & wr_res & f;
      assign clr_req = wr_en & ~wr_res;

      pulse_bit_timer #(.PULSE_LEN(PULSE_LEN)) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .set_req(set_req),
        .clr_req(clr_req),
        .bit_q  (out_bits[i]),
        .active (active[i])
      );
    end else begin : g_plain
      logic q;
      always_ff @(posedge clk) begin
        if (rst)        q <= RESET_VAL[i];
        else if (wr_en) q <= wr_res;
      end
      assign out_bits[i] = q;
      assign active[i]   = 1'b0;
    end
  end

  // Samples the registered strobe state, so it trails the strobes by a cycle.
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= |active;
  end

  assign rd_data = DATA_W'(out_bits) << LSB;

  // Out-of-field write bits are deliberately ignored.
  logic unused_data;
  assign unused_data = ^(wr_data & ~FIELD);

endmodule
